rr_arb_mux: RTL and testbench

RR_ARB_MUX -- requirements
Module: rr_arb_mux

---
 rtl/rr_arb_mux_if.sv | 26 ++
 rtl/rr_arb_mux.sv | 69 ++++++
 tb/tb_rr_arb_mux.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/rr_arb_mux_if.sv
// rtl/rr_arb_mux_if.sv - N-channel input / single output handshake bundle for rr_arb_mux
interface rr_arb_mux_if #(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int SELW  = $clog2(N)
);
    logic [N-1:0]       in_valid;
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_ready;
    logic               force_en;
    logic [SELW-1:0]    force_sel;
    logic               out_valid;
    logic [WIDTH-1:0]   out_data;
    logic [SELW-1:0]    out_sel;
    logic               out_ready;

    modport master (
        output in_valid, in_data, force_en, force_sel, out_ready,
        input  in_ready, out_valid, out_data, out_sel
    );

    modport slave (
        input  in_valid, in_data, force_en, force_sel, out_ready,
        output in_ready, out_valid, out_data, out_sel
    );
endinterface

// File: rtl/rr_arb_mux.sv
// rtl/rr_arb_mux.sv - round-robin arbitrating mux with force override and a registered output stage
module rr_arb_mux #(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int SELW  = $clog2(N)
) (
    input  logic        clk,
    input  logic        rst_n,
    rr_arb_mux_if.slave bus
);
    logic [SELW-1:0]  rr_ptr;
    logic             accept;
    logic [N-1:0]     eligible;
    logic             found;
    logic [SELW-1:0]  grant;
    logic [WIDTH-1:0] grant_data;

    assign accept = !bus.out_valid || bus.out_ready;

    // An out-of-range force_sel matches no index, so nothing becomes eligible.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < N; i++) begin
            eligible[i] = bus.in_valid[i] && (!bus.force_en || (32'(bus.force_sel) == i));
        end
    end

    always_comb begin
        int idx;
        found      = 1'b0;
        grant      = '0;
        grant_data = '0;
        for (int k = 0; k < N; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= N) idx = idx - N;
            if (!found && eligible[idx]) begin
                found      = 1'b1;
                grant      = SELW'(idx);
                grant_data = bus.in_data[idx*WIDTH +: WIDTH];
            end
        end
    end

    // Ready depends only on valid/force/pointer state, never on data.
    always_comb begin
        bus.in_ready = '0;
        if (rst_n && accept && found) bus.in_ready[grant] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_sel   <= '0;
            rr_ptr        <= '0;
        end else if (accept) begin
            if (found) begin
                bus.out_valid <= 1'b1;
                bus.out_data  <= grant_data;
                bus.out_sel   <= grant;
                if (!bus.force_en) begin
                    rr_ptr <= (grant == SELW'(N-1)) ? '0 : grant + 1'b1;
                end
            end else begin
                bus.out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_rr_arb_mux.sv
// tb/tb_rr_arb_mux.sv - randomized and directed self-checking bench for rr_arb_mux
module tb_rr_arb_mux;
    localparam int W = 32;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rr_arb_mux_if #(.WIDTH(W), .N(N)) bus ();
    rr_arb_mux #(.WIDTH(W), .N(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    rr_arb_mux_if #(.WIDTH(8), .N(3)) bus3 ();
    rr_arb_mux #(.WIDTH(8), .N(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

    int passed = 0;
    int total  = 0;

    int             m_ptr;
    bit             m_valid;
    logic [W-1:0]   m_data;
    int             m_sel;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_ptr   = 0;
        m_valid = 1'b0;
        m_data  = '0;
        m_sel   = 0;
    endtask

    function automatic int model_grant();
        int c;
        for (int k = 0; k < N; k++) begin
            c = (m_ptr + k) % N;
            if (bus.in_valid[c] && (!bus.force_en || int'(bus.force_sel) == c)) return c;
        end
        return -1;
    endfunction

    task automatic set_in(logic [N-1:0] v, bit ordy, bit fen, logic [1:0] fsel);
        bus.in_valid  = v;
        bus.out_ready = ordy;
        bus.force_en  = fen;
        bus.force_sel = fsel;
    endtask

    task automatic known_data();
        bus.in_data = {32'h87654321, 32'h12345678, 32'h55555555, 32'hAAAAAAAA};
    endtask

    // Called at a negedge with inputs already applied; returns at the following negedge.
    task automatic cycle(string tag);
        int g;
        bit acc;
        logic [N-1:0] er;
        #1;
        g   = model_grant();
        acc = !m_valid || bus.out_ready;
        er  = '0;
        if (acc && g >= 0) er[g] = 1'b1;
        chk({tag, ".in_ready"}, 64'(bus.in_ready), 64'(er));
        @(posedge clk);
        if (acc) begin
            if (g >= 0) begin
                m_data  = bus.in_data[g*W +: W];
                m_sel   = g;
                m_valid = 1'b1;
                if (!bus.force_en) m_ptr = (g + 1) % N;
            end else begin
                m_valid = 1'b0;
            end
        end
        @(negedge clk);
        chk({tag, ".out_valid"}, 64'(bus.out_valid), 64'(m_valid));
        chk({tag, ".out_sel"},   64'(bus.out_sel),   64'(m_sel));
        chk({tag, ".out_data"},  64'(bus.out_data),  64'(m_data));
    endtask

    initial begin
        int rr_exp[5];
        rr_exp = '{0, 1, 2, 3, 0};

        bus3.in_valid = '0; bus3.in_data = '0; bus3.force_en = 1'b0;
        bus3.force_sel = '0; bus3.out_ready = 1'b1;
        known_data();
        set_in(4'b1111, 1'b1, 1'b0, 2'd0);
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk("rst.out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst.out_data",  64'(bus.out_data),  64'd0);
        chk("rst.in_ready",  64'(bus.in_ready),  64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            cycle("rr");
            chk("rr.seq", 64'(bus.out_sel), 64'(rr_exp[i]));
        end

        set_in(4'b0100, 1'b1, 1'b0, 2'd0); cycle("wrap.to3");
        set_in(4'b0010, 1'b1, 1'b0, 2'd0); cycle("wrap.ch1");
        chk("wrap.ch1.sel", 64'(bus.out_sel), 64'd1);
        set_in(4'b1000, 1'b1, 1'b0, 2'd0); cycle("wrap.ch3");
        chk("wrap.ch3.sel", 64'(bus.out_sel), 64'd3);
        set_in(4'b1111, 1'b1, 1'b0, 2'd0); cycle("wrap.ptr0");
        chk("wrap.ptr0.sel", 64'(bus.out_sel), 64'd0);

        set_in(4'b1111, 1'b0, 1'b0, 2'd0);
        for (int i = 0; i < 3; i++) begin
            cycle("bp.stall");
            chk("bp.hold", 64'(bus.out_data), 64'h0000_0000_AAAA_AAAA);
        end
        set_in(4'b1111, 1'b1, 1'b0, 2'd0); cycle("bp.release");
        chk("bp.release.data", 64'(bus.out_data), 64'h0000_0000_5555_5555);

        set_in(4'b1111, 1'b1, 1'b1, 2'd2);
        for (int i = 0; i < 3; i++) begin
            cycle("force");
            chk("force.sel", 64'(bus.out_sel), 64'd2);
        end
        set_in(4'b1111, 1'b1, 1'b0, 2'd0); cycle("force.exit");
        chk("force.exit.sel", 64'(bus.out_sel), 64'd2);
        cycle("force.next");

        set_in(4'b1111, 1'b0, 1'b1, 2'd1); cycle("fchg.a");
        set_in(4'b1111, 1'b0, 1'b1, 2'd3); cycle("fchg.b");
        set_in(4'b1111, 1'b1, 1'b1, 2'd3); cycle("fchg.c");
        chk("fchg.sel", 64'(bus.out_sel), 64'd3);

        for (int i = 0; i < 300; i++) begin
            for (int c = 0; c < N; c++) bus.in_data[c*W +: W] = $urandom;
            set_in(4'($urandom), ($urandom % 4) != 0, ($urandom % 8) == 0, 2'($urandom));
            cycle("rand");
        end

        known_data();
        set_in(4'b1111, 1'b1, 1'b0, 2'd0); cycle("arst.pre");
        chk("arst.pre.valid", 64'(bus.out_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.out_valid", 64'(bus.out_valid), 64'd0);
        chk("arst.out_data",  64'(bus.out_data),  64'd0);
        chk("arst.in_ready",  64'(bus.in_ready),  64'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cycle("arst.first");
        chk("arst.first.sel", 64'(bus.out_sel), 64'd0);

        bus3.in_valid = 3'b111; bus3.in_data = 24'h33_22_11;
        bus3.out_ready = 1'b1; bus3.force_en = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("n3.load.valid", 64'(bus3.out_valid), 64'd1);
        chk("n3.load.data",  64'(bus3.out_data),  64'h11);
        bus3.force_en = 1'b1; bus3.force_sel = 2'd3; bus3.out_ready = 1'b0;
        #1;
        chk("n3.oob.rdy0", 64'(bus3.in_ready), 64'd0);
        @(posedge clk); @(negedge clk);
        chk("n3.oob.held", 64'(bus3.out_valid), 64'd1);
        bus3.out_ready = 1'b1;
        #1;
        chk("n3.oob.rdy1", 64'(bus3.in_ready), 64'd0);
        @(posedge clk); @(negedge clk);
        chk("n3.oob.drain", 64'(bus3.out_valid), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
